// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = a - b - bin, one bit per clock through a
// single full-adder slice. a + ~b + ~bin gives the difference; the final carry is the inverse of the borrow.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             c;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             s, c_nxt, accept, last;
    logic [WIDTH-1:0] r_nxt;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        s      = a_sh[0] ^ b_sh[0] ^ c;
        c_nxt  = maj3(a_sh[0], b_sh[0], c);
        r_nxt  = {s, r_sh[WIDTH-1:1]};
        accept = in_valid && (state == IDLE);
        last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            c     <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                c   <= ~bin;
                cnt <= '0;
            end else if (state == SHIFT) begin
                c   <= c_nxt;
                cnt <= cnt + 1'b1;
                // The last slice's sum and carry are folded straight into the result.
                if (last) begin
                    d    <= r_nxt;
                    bout <= ~c_nxt;
                    zero <= (r_nxt == '0);
                end
            end
        end
    end

    // Operand and result shift registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= ~b;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= r_nxt;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, backpressure, reset
// abort, random ops and an exhaustive back-to-back sweep against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] d;
    logic         bout;
    logic         zero;

    int checks = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer subtraction, result wrapped to W bits.
    task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         output logic [W-1:0] ed, output logic eb, output logic ez);
        int df;
        df = int'(ai) - int'(bi) - int'(ci);
        ed = df[W-1:0];
        eb = (df < 0);
        ez = (ed == '0);
    endtask

    // Drive one operation from IDLE; hold out_ready low for 'hold' cycles of DONE.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                          input int hold, output logic [W-1:0] dq, output logic bq,
                          output logic zq, output int lat);
        a = ai; b = bi; bin = ci; in_valid = 1'b1; out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        lat = 0;
        dq = 'x; bq = 1'bx; zq = 1'bx;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            lat = -1;
            return;
        end
        dq = d; bq = bout; zq = zero;
        for (int i = 0; i < hold; i++) tick();
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        checks++;
        if ({in_ready, out_valid, d, bout, zero} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold: rdy=%b vld=%b d=%b bout=%b zero=%b required rdy=1 vld=0 d=0 bout=0 zero=0",
                     in_ready, out_valid, d, bout, zero);
        end
        #2 rst = 1'b0;
        tick();
        // Park in DONE with a nonzero result, then reset asynchronously mid-cycle.
        a = 4'b0011; b = 4'b0101; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        checks++;
        if (!out_valid || d !== 4'b1110 || bout !== 1'b1) begin
            failures++;
            $display("FAIL reset_setup: vld=%b d=%b bout=%b required vld=1 d=1110 bout=1", out_valid, d, bout);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, d, bout, zero} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_async: rdy=%b vld=%b d=%b bout=%b zero=%b required rdy=1 vld=0 d=0 bout=0 zero=0",
                     in_ready, out_valid, d, bout, zero);
        end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [W-1:0] ta [6] = '{4'b0101, 4'b1101, 4'b1111, 4'b0011, 4'b0000, 4'b0011};
        logic [W-1:0] tb [6] = '{4'b0011, 4'b0011, 4'b1101, 4'b0101, 4'b0000, 4'b0011};
        logic         tc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] td [6] = '{4'b0010, 4'b1001, 4'b0001, 4'b1110, 4'b1111, 4'b0000};
        logic         tbo[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic         tz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] dq;
        logic         bq, zq;
        int           lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], tc[i], 0, dq, bq, zq, lat);
            checks++;
            if (lat != W) begin
                failures++;
                $display("FAIL basic_latency[%0d]: got %0d cycles required %0d", i, lat, W);
            end
            checks++;
            if ({dq, bq, zq} !== {td[i], tbo[i], tz[i]}) begin
                failures++;
                $display("FAIL basic_result[%0d]: d=%b bout=%b zero=%b required d=%b bout=%b zero=%b",
                         i, dq, bq, zq, td[i], tbo[i], tz[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [W-1:0] d0;
        logic         b0, z0;
        a = 4'b0101; b = 4'b0011; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        d0 = d; b0 = bout; z0 = zero;
        checks++;
        if (!out_valid || {d0, b0, z0} !== {4'b0010, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL bp_result: vld=%b d=%b bout=%b zero=%b required vld=1 d=0010 bout=0 zero=0",
                     out_valid, d0, b0, z0);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {d, bout, zero} !== {d0, b0, z0}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b d=%b bout=%b zero=%b required vld=1 rdy=0 d=%b bout=%b zero=%b",
                         i, out_valid, in_ready, d, bout, zero, d0, b0, z0);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        logic [W-1:0] dq;
        logic         bq, zq;
        int           lat;
        a = 4'b0110; b = 4'b0001; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #2 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_valid: out_valid seen %0d cycles required 0", seen);
        end
        run_op(4'b1001, 4'b0011, 1'b1, 0, dq, bq, zq, lat);
        checks++;
        if (lat != W || {dq, bq} !== {4'b0101, 1'b0}) begin
            failures++;
            $display("FAIL abort_next_op: lat=%0d d=%b bout=%b required lat=%0d d=0101 bout=0", lat, dq, bq, W);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ai, bi, dq, ed;
        logic         ci, bq, zq, eb, ez;
        int           lat;
        for (int i = 0; i < 30; i++) begin
            ai = W'($urandom); bi = W'($urandom); ci = 1'($urandom);
            run_op(ai, bi, ci, int'($urandom_range(0, 3)), dq, bq, zq, lat);
            model(ai, bi, ci, ed, eb, ez);
            checks++;
            if (lat != W || {dq, bq, zq} !== {ed, eb, ez}) begin
                failures++;
                $display("FAIL random[%0d] %b-%b-%b: lat=%0d d=%b bout=%b zero=%b required lat=%0d d=%b bout=%b zero=%b",
                         i, ai, bi, ci, lat, dq, bq, zq, W, ed, eb, ez);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qd[$];
        logic         qb[$], qz[$];
        int           qacc[$];
        int           cyc, idx, last_acc, acc;
        logic [W-1:0] ed;
        logic         eb, ez;
        cyc = 0; idx = 0; last_acc = -1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        while ((idx < 512 || qd.size() > 0) && cyc < 512 * (W + 2) + 100) begin
            if (out_valid) begin
                checks++;
                if (qd.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_spurious: out_valid at cycle %0d with nothing outstanding", cyc);
                end else begin
                    acc = qacc.pop_front();
                    ed = qd.pop_front(); eb = qb.pop_front(); ez = qz.pop_front();
                    if (cyc != acc + W || {d, bout, zero} !== {ed, eb, ez}) begin
                        failures++;
                        $display("FAIL b2b_result: at cycle %0d d=%b bout=%b zero=%b required cycle %0d d=%b bout=%b zero=%b",
                                 cyc, d, bout, zero, acc + W, ed, eb, ez);
                    end
                end
            end
            if (in_ready) begin
                if (idx < 512) begin
                    a = idx[W-1:0]; b = idx[2*W-1:W]; bin = idx[2*W];
                    model(a, b, bin, ed, eb, ez);
                    qd.push_back(ed); qb.push_back(eb); qz.push_back(ez);
                    qacc.push_back(cyc + 1);
                    if (last_acc >= 0) begin
                        checks++;
                        if (cyc + 1 - last_acc != W + 2) begin
                            failures++;
                            $display("FAIL b2b_spacing: accepts %0d cycles apart required %0d", cyc + 1 - last_acc, W + 2);
                        end
                    end
                    last_acc = cyc + 1;
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 512 || qd.size() != 0) begin
            failures++;
            $display("FAIL b2b_timeout: issued %0d outstanding %0d required 512 and 0", idx, qd.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
